pcap_dma_writer: RTL and testbench

Downstream consumer of the position-capture core's output word stream. It buffers captured 32-bit words in an internal FIFO and throttles the capture core through `dma_full_o`. It drains the FIFO as fixed-length bursts to host memory, into host-supplied blocks. When a block fills, or when capture ends, it interrupts the host.

---
 rtl/pcap_dma_pkg.sv | 19 +
 rtl/pcap_dma_fifo.sv | 67 ++++++
 rtl/pcap_dma_writer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pcap_dma_writer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcap_dma_pkg.sv
// Shared types and constants for the position-capture DMA writer.
package pcap_dma_pkg;

    // Burst engine states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_NEXT
    } dma_state_e;

    // IRQ_STATUS bit positions
    localparam int unsigned IRQ_BLK_FULL  = 0;
    localparam int unsigned IRQ_DONE      = 1;
    localparam int unsigned IRQ_OVF       = 2;
    localparam int unsigned IRQ_NOADDR    = 3;
    localparam int unsigned IRQ_WORDS_LSB = 8;

endpackage

// File: rtl/pcap_dma_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
module pcap_dma_fifo #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_c_o,
    output logic [AW:0]   level_o
);

    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          wr_ok_c;
    logic          rd_ok_c;

    // Writes are dropped when full, reads ignored when empty
    always_comb begin
        wr_ok_c = wr_en_i && (level_q != LW'(DEPTH));
        rd_ok_c = rd_en_i && (level_q != '0);
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (wr_ok_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy; clear empties the FIFO in one cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_ok_c, rd_ok_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_data_c_o = mem_q[rd_ptr_q];
    assign level_o     = level_q;

endmodule

// File: rtl/pcap_dma_writer.sv
// Buffers capture words and drains them as bursts into host-supplied blocks.
module pcap_dma_writer
    import pcap_dma_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 10,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned AFULL_MARGIN = 64
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] pcap_dat_i,
    input  logic        pcap_dat_valid_i,
    input  logic        pcap_done_i,
    output logic        dma_full_o,
    input  logic        DMA_RESET,
    input  logic [31:0] DMA_ADDR,
    input  logic        DMA_ADDR_WSTB,
    input  logic [31:0] BLOCK_SIZE,
    output logic        wr_req_o,
    input  logic        wr_ack_i,
    output logic [31:0] wr_addr_o,
    output logic [7:0]  wr_len_o,
    output logic [31:0] wr_data_o,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic        irq_o,
    output logic [31:0] IRQ_STATUS,
    output logic [31:0] BLOCK_ADDR
);

    localparam int unsigned LW      = FIFO_AW + 1;
    localparam int unsigned DEPTH   = 2**FIFO_AW;
    localparam logic [31:0] BURST_W = 32'(BURST_LEN);

    dma_state_e  state_q;
    logic        wr_req_q;
    logic [31:0] wr_addr_q;
    logic [7:0]  wr_len_q;
    logic [31:0] wr_data_q;
    logic        wr_valid_q;
    logic        irq_q;
    logic [31:0] irq_status_q;
    logic [31:0] block_addr_q;
    logic        dma_full_q;
    logic [7:0]  beats_q;
    logic        flush_q;
    logic        blk_active_q;
    logic [31:0] blk_base_q;
    logic [31:0] cur_addr_q;
    logic [31:0] blk_bytes_q;
    logic [31:0] aq0_q;
    logic [31:0] aq1_q;
    logic [1:0]  aq_cnt_q;

    logic [LW-1:0] fifo_level;
    logic [31:0]   fifo_head_c;
    logic [31:0]   level32_c;
    logic          fifo_full_c;
    logic          has_burst_c;
    logic          want_c;
    logic [31:0]   burst_words_c;
    logic          aq_pop_c;
    logic          aq_push_c;
    logic          fifo_pop_c;
    logic [31:0]   burst_bytes_c;
    logic [31:0]   blk_bytes_nxt_c;

    pcap_dma_fifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clr_i       (DMA_RESET),
        .wr_en_i     (pcap_dat_valid_i),
        .wr_data_i   (pcap_dat_i),
        .rd_en_i     (fifo_pop_c),
        .rd_data_c_o (fifo_head_c),
        .level_o     (fifo_level)
    );

    // Burst sizing, queue handshakes and FIFO pop
    always_comb begin
        level32_c       = 32'(fifo_level);
        fifo_full_c     = (level32_c == 32'(DEPTH));
        has_burst_c     = (level32_c >= BURST_W);
        want_c          = has_burst_c || (flush_q && (level32_c != 32'd0));
        burst_words_c   = has_burst_c ? BURST_W : level32_c;
        aq_pop_c        = !blk_active_q && (aq_cnt_q != 2'd0);
        aq_push_c       = DMA_ADDR_WSTB && (aq_cnt_q != 2'd2);
        fifo_pop_c      = ((state_q == ST_REQ) && wr_ack_i) ||
                          ((state_q == ST_DATA) && wr_valid_q && wr_ready_i && (beats_q != 8'd0));
        burst_bytes_c   = (32'(wr_len_q) + 32'd1) << 2;
        blk_bytes_nxt_c = blk_bytes_q + burst_bytes_c;
    end

    // Two-entry block address queue; head is consumed when no block is active
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            aq0_q    <= '0;
            aq1_q    <= '0;
            aq_cnt_q <= '0;
        end else if (DMA_RESET) begin
            aq_cnt_q <= '0;
        end else begin
            case ({aq_pop_c, aq_push_c})
                2'b10: begin
                    aq0_q    <= aq1_q;
                    aq_cnt_q <= aq_cnt_q - 2'd1;
                end
                2'b01: begin
                    if (aq_cnt_q == 2'd0) begin
                        aq0_q <= DMA_ADDR;
                    end else begin
                        aq1_q <= DMA_ADDR;
                    end
                    aq_cnt_q <= aq_cnt_q + 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new address becomes the head
                    aq0_q <= DMA_ADDR;
                end
                default: begin
                    aq_cnt_q <= aq_cnt_q;
                end
            endcase
        end
    end

    // Burst engine, block tracking, flush and interrupt status
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
            irq_q        <= 1'b0;
            irq_status_q <= '0;
            block_addr_q <= '0;
            dma_full_q   <= 1'b0;
            beats_q      <= '0;
            flush_q      <= 1'b0;
            blk_active_q <= 1'b0;
            blk_base_q   <= '0;
            cur_addr_q   <= '0;
            blk_bytes_q  <= '0;
        end else if (DMA_RESET) begin
            state_q      <= ST_IDLE;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
            irq_q        <= 1'b0;
            irq_status_q <= '0;
            block_addr_q <= '0;
            dma_full_q   <= 1'b0;
            beats_q      <= '0;
            flush_q      <= 1'b0;
            blk_active_q <= 1'b0;
            blk_base_q   <= '0;
            cur_addr_q   <= '0;
            blk_bytes_q  <= '0;
        end else begin
            irq_q      <= 1'b0;
            dma_full_q <= (32'(DEPTH) - level32_c) < 32'(AFULL_MARGIN);

            if (pcap_dat_valid_i && fifo_full_c) begin
                irq_status_q[IRQ_OVF] <= 1'b1;
            end

            if (aq_pop_c) begin
                blk_active_q <= 1'b1;
                blk_base_q   <= aq0_q;
                cur_addr_q   <= aq0_q;
                blk_bytes_q  <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (blk_active_q && want_c) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= cur_addr_q;
                        wr_len_q  <= 8'(burst_words_c - 32'd1);
                        state_q   <= ST_REQ;
                    end else if (flush_q && (level32_c == 32'd0)) begin
                        irq_q                                <= 1'b1;
                        irq_status_q[IRQ_BLK_FULL]           <= 1'b0;
                        irq_status_q[IRQ_DONE]               <= 1'b1;
                        irq_status_q[31:IRQ_WORDS_LSB]       <= blk_bytes_q[25:2];
                        flush_q                              <= 1'b0;
                        // An untouched block stays available for the next capture
                        if (blk_active_q && (blk_bytes_q != 32'd0)) begin
                            blk_active_q <= 1'b0;
                            block_addr_q <= blk_base_q;
                        end
                    end else if (!blk_active_q && (aq_cnt_q == 2'd0) && want_c) begin
                        irq_status_q[IRQ_NOADDR] <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (wr_ack_i) begin
                        wr_req_q   <= 1'b0;
                        wr_valid_q <= 1'b1;
                        wr_data_q  <= fifo_head_c;
                        beats_q    <= wr_len_q;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_ready_i) begin
                        if (beats_q == 8'd0) begin
                            wr_valid_q <= 1'b0;
                            state_q    <= ST_NEXT;
                        end else begin
                            wr_data_q <= fifo_head_c;
                            beats_q   <= beats_q - 8'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    cur_addr_q <= cur_addr_q + burst_bytes_c;
                    // >= guards against a partial flush burst leaving the count misaligned
                    if (blk_bytes_nxt_c >= BLOCK_SIZE) begin
                        irq_q                          <= 1'b1;
                        irq_status_q[IRQ_BLK_FULL]     <= 1'b1;
                        irq_status_q[IRQ_DONE]         <= 1'b0;
                        irq_status_q[31:IRQ_WORDS_LSB] <= blk_bytes_nxt_c[25:2];
                        block_addr_q                   <= blk_base_q;
                        blk_active_q                   <= 1'b0;
                        blk_bytes_q                    <= '0;
                    end else begin
                        blk_bytes_q <= blk_bytes_nxt_c;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A done pulse always arms a flush, even as a previous one completes
            if (pcap_done_i) begin
                flush_q <= 1'b1;
            end
        end
    end

    assign dma_full_o = dma_full_q;
    assign wr_req_o   = wr_req_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_len_o   = wr_len_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = wr_valid_q;
    assign irq_o      = irq_q;
    assign IRQ_STATUS = irq_status_q;
    assign BLOCK_ADDR = block_addr_q;

endmodule

// File: tb/tb_pcap_dma_writer.sv
// Directed bench for pcap_dma_writer (FIFO_AW=6, BURST_LEN=16, AFULL_MARGIN=16).
module tb_pcap_dma_writer;

    logic        clk_i;
    logic        reset_n_i;
    logic [31:0] pcap_dat_i;
    logic        pcap_dat_valid_i;
    logic        pcap_done_i;
    logic        dma_full_o;
    logic        DMA_RESET;
    logic [31:0] DMA_ADDR;
    logic        DMA_ADDR_WSTB;
    logic [31:0] BLOCK_SIZE;
    logic        wr_req_o;
    logic        wr_ack_i;
    logic [31:0] wr_addr_o;
    logic [7:0]  wr_len_o;
    logic [31:0] wr_data_o;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic        irq_o;
    logic [31:0] IRQ_STATUS;
    logic [31:0] BLOCK_ADDR;

    pcap_dma_writer #(
        .FIFO_AW      (6),
        .BURST_LEN    (16),
        .AFULL_MARGIN (16)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .pcap_dat_i       (pcap_dat_i),
        .pcap_dat_valid_i (pcap_dat_valid_i),
        .pcap_done_i      (pcap_done_i),
        .dma_full_o       (dma_full_o),
        .DMA_RESET        (DMA_RESET),
        .DMA_ADDR         (DMA_ADDR),
        .DMA_ADDR_WSTB    (DMA_ADDR_WSTB),
        .BLOCK_SIZE       (BLOCK_SIZE),
        .wr_req_o         (wr_req_o),
        .wr_ack_i         (wr_ack_i),
        .wr_addr_o        (wr_addr_o),
        .wr_len_o         (wr_len_o),
        .wr_data_o        (wr_data_o),
        .wr_valid_o       (wr_valid_o),
        .wr_ready_i       (wr_ready_i),
        .irq_o            (irq_o),
        .IRQ_STATUS       (IRQ_STATUS),
        .BLOCK_ADDR       (BLOCK_ADDR)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int          n_chk;
    int          n_fail;
    int          rdy_mode;
    bit          tog;
    bit          req_prev;
    bit          stall_prev;
    logic [31:0] stall_data;
    int          irq_cnt;
    logic [31:0] b_addr[$];
    logic [7:0]  b_len[$];
    logic [31:0] beats[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: respond to the bus, log handshakes, advance to 1 ns after the edge
    task automatic step();
        wr_ack_i = wr_req_o && req_prev;
        case (rdy_mode)
            0:       wr_ready_i = 1'b1;
            1:       wr_ready_i = tog;
            default: wr_ready_i = 1'b0;
        endcase
        tog = !tog;
        if (wr_req_o && wr_ack_i) begin
            b_addr.push_back(wr_addr_o);
            b_len.push_back(wr_len_o);
        end
        if (wr_valid_o && wr_ready_i) beats.push_back(wr_data_o);
        if (stall_prev && wr_valid_o) chk("stall_hold", wr_data_o, stall_data);
        stall_prev = wr_valid_o && !wr_ready_i;
        stall_data = wr_data_o;
        if (irq_o) irq_cnt++;
        req_prev = wr_req_o && !wr_ack_i;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        b_addr.delete();
        b_len.delete();
        beats.delete();
        irq_cnt = 0;
    endtask

    task automatic push_addr(input logic [31:0] a);
        DMA_ADDR      = a;
        DMA_ADDR_WSTB = 1'b1;
        step();
        DMA_ADDR_WSTB = 1'b0;
    endtask

    task automatic push_words(input logic [31:0] base, input int n, input bit done_last);
        for (int i = 0; i < n; i++) begin
            pcap_dat_i       = base + 32'(i);
            pcap_dat_valid_i = 1'b1;
            pcap_done_i      = done_last && (i == n - 1);
            step();
        end
        pcap_dat_valid_i = 1'b0;
        pcap_done_i      = 1'b0;
    endtask

    task automatic dma_reset_pulse();
        DMA_RESET = 1'b1;
        step();
        DMA_RESET = 1'b0;
    endtask

    task automatic run_until_irq(input string tag, input int max);
        int start;
        int n;
        start = irq_cnt;
        n = 0;
        while (irq_cnt == start && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(irq_cnt > start), 32'd1);
    endtask

    task automatic run_until_beats(input string tag, input int nb, input int max);
        int n;
        n = 0;
        while (beats.size() < nb && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(beats.size() >= nb), 32'd1);
    endtask

    task automatic run_until_valid(input string tag, input int max);
        int n;
        n = 0;
        while (!wr_valid_o && n < max) begin
            step();
            n++;
        end
        chk(tag, 32'(wr_valid_o), 32'd1);
    endtask

    task automatic chk_beats(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk(tag, (i < beats.size()) ? beats[i] : 32'hDEAD_BEEF, base + 32'(i));
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; rdy_mode = 0; tog = 1'b0; req_prev = 1'b0;
        stall_prev = 1'b0; stall_data = '0; irq_cnt = 0;
        reset_n_i = 1'b0; pcap_dat_i = '0; pcap_dat_valid_i = 1'b0; pcap_done_i = 1'b0;
        DMA_RESET = 1'b0; DMA_ADDR = '0; DMA_ADDR_WSTB = 1'b0; BLOCK_SIZE = 32'd128;
        wr_ack_i = 1'b0; wr_ready_i = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_dma_full", 32'(dma_full_o), 32'd0);
        chk("rst_wr_req", 32'(wr_req_o), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_wr_addr", wr_addr_o, 32'd0);
        chk("rst_wr_len", 32'(wr_len_o), 32'd0);
        chk("rst_wr_data", wr_data_o, 32'd0);
        chk("rst_irq_status", IRQ_STATUS, 32'd0);
        chk("rst_block_addr", BLOCK_ADDR, 32'd0);
        reset_n_i = 1'b1;
        step();

        // Full block: 32 words into a 128-byte block -> two bursts, one irq
        clear_logs();
        push_addr(32'h1000_0000);
        push_words(32'd0, 32, 1'b0);
        run_until_irq("t1_irq_timeout", 200);
        chk("t1_burst_count", 32'(b_addr.size()), 32'd2);
        chk("t1_addr0", b_addr[0], 32'h1000_0000);
        chk("t1_len0", 32'(b_len[0]), 32'd15);
        chk("t1_addr1", (b_addr.size() > 1) ? b_addr[1] : 32'hDEAD_BEEF, 32'h1000_0040);
        chk("t1_len1", (b_len.size() > 1) ? 32'(b_len[1]) : 32'hDEAD_BEEF, 32'd15);
        chk_beats("t1_data", 32'd0, 32);
        chk("t1_status", IRQ_STATUS, 32'h0000_2001);
        chk("t1_block_addr", BLOCK_ADDR, 32'h1000_0000);
        step();
        chk("t1_irq_pulse", 32'(irq_o), 32'd0);
        chk("t1_irq_count", 32'(irq_cnt), 32'd1);

        // Flush: 5 words with done on the last one -> len 4, then done irq
        clear_logs();
        push_addr(32'h2000_0000);
        push_words(32'd100, 5, 1'b1);
        run_until_irq("t2_irq_timeout", 60);
        chk("t2_burst_count", 32'(b_addr.size()), 32'd1);
        chk("t2_addr", b_addr[0], 32'h2000_0000);
        chk("t2_len", 32'(b_len[0]), 32'd4);
        chk_beats("t2_data", 32'd100, 5);
        chk("t2_status", IRQ_STATUS, 32'h0000_0502);

        // Ready toggling every cycle: no loss, no duplicates, data held on stall
        clear_logs();
        push_addr(32'h3000_0000);
        rdy_mode = 1;
        push_words(32'd200, 16, 1'b0);
        run_until_beats("t3_beats_timeout", 16, 100);
        repeat (5) step();
        chk("t3_addr", b_addr[0], 32'h3000_0000);
        chk("t3_len", 32'(b_len[0]), 32'd15);
        chk_beats("t3_data", 32'd200, 16);
        rdy_mode = 0;
        dma_reset_pulse();

        // No address: 20 words -> status[3], no request; an address releases a burst
        clear_logs();
        push_words(32'd300, 20, 1'b0);
        repeat (10) step();
        chk("t4_no_req", 32'(b_addr.size()), 32'd0);
        chk("t4_status", IRQ_STATUS, 32'h0000_0008);
        push_addr(32'h4000_0000);
        run_until_beats("t4_beats_timeout", 16, 100);
        chk("t4_addr", b_addr[0], 32'h4000_0000);
        chk_beats("t4_data", 32'd300, 16);
        dma_reset_pulse();

        // Overflow: no address, no ready, continuous writes into a 64-deep FIFO
        clear_logs();
        rdy_mode = 2;
        for (int i = 1; i <= 65; i++) begin
            pcap_dat_i       = 32'(i);
            pcap_dat_valid_i = 1'b1;
            step();
            if (i == 49) chk("t5_full_low", 32'(dma_full_o), 32'd0);
            if (i == 50) chk("t5_full_high", 32'(dma_full_o), 32'd1);
            if (i == 64) chk("t5_no_ovf", IRQ_STATUS, 32'h0000_0008);
            if (i == 65) chk("t5_ovf", IRQ_STATUS, 32'h0000_000C);
        end
        pcap_dat_valid_i = 1'b0;

        // DMA_RESET in the middle of a stalled burst
        clear_logs();
        push_addr(32'h5000_0000);
        run_until_valid("t6_valid_timeout", 20);
        chk("t6_addr", b_addr[0], 32'h5000_0000);
        dma_reset_pulse();
        chk("t6_valid_drop", 32'(wr_valid_o), 32'd0);
        chk("t6_req_drop", 32'(wr_req_o), 32'd0);
        chk("t6_status_clr", IRQ_STATUS, 32'd0);
        chk("t6_full_clr", 32'(dma_full_o), 32'd0);
        clear_logs();
        pcap_done_i = 1'b1;
        step();
        pcap_done_i = 1'b0;
        run_until_irq("t6_irq_timeout", 20);
        chk("t6_empty_done", IRQ_STATUS, 32'h0000_0002);
        chk("t6_no_burst", 32'(b_addr.size()), 32'd0);

        // Async reset in the middle of a stalled burst
        clear_logs();
        push_addr(32'h6000_0000);
        push_words(32'd400, 16, 1'b0);
        run_until_valid("t7_valid_timeout", 40);
        reset_n_i = 1'b0;
        #1;
        chk("t7_valid_drop", 32'(wr_valid_o), 32'd0);
        chk("t7_req_drop", 32'(wr_req_o), 32'd0);
        chk("t7_status_clr", IRQ_STATUS, 32'd0);
        chk("t7_block_clr", BLOCK_ADDR, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i  = 1'b1;
        stall_prev = 1'b0;
        req_prev   = 1'b0;
        rdy_mode   = 0;
        clear_logs();
        pcap_done_i = 1'b1;
        step();
        pcap_done_i = 1'b0;
        run_until_irq("t7_irq_timeout", 20);
        chk("t7_empty_done", IRQ_STATUS, 32'h0000_0002);
        chk("t7_no_burst", 32'(b_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
